// File: rtl/iddr_gearbox_if.sv
// iddr_gearbox_if
//   Lane-side bundle of the IDDR gearbox.
//   master : the IDDR stage / lane controller. It drives Q1, Q2 and BITSLIP and
//            receives the parallel word.
//   slave  : the gearbox. It consumes the DDR bit pair and produces DOUT,
//            DVALID, SLIP_CNT and ALIGNED.
//   Signals:
//     Q1       earlier-in-time DDR bit of the current cycle
//     Q2       later-in-time DDR bit of the current cycle
//     BITSLIP  one-cycle pulse that moves the word boundary 1 bit later
//     DOUT     assembled WIDTH-bit word, MSB = oldest bit
//     DVALID   one-cycle strobe, DOUT valid
//     SLIP_CNT accepted slips modulo WIDTH
//     ALIGNED  auto-align locked
interface iddr_gearbox_if #(
    parameter int unsigned WIDTH = 8
);
    logic                     Q1;
    logic                     Q2;
    logic                     BITSLIP;
    logic [WIDTH-1:0]         DOUT;
    logic                     DVALID;
    logic [$clog2(WIDTH)-1:0] SLIP_CNT;
    logic                     ALIGNED;

    modport master (
        output Q1, Q2, BITSLIP,
        input  DOUT, DVALID, SLIP_CNT, ALIGNED
    );

    modport slave (
        input  Q1, Q2, BITSLIP,
        output DOUT, DVALID, SLIP_CNT, ALIGNED
    );
endinterface

// File: rtl/iddr_gearbox.sv
// iddr_gearbox
//   Packs the 2-bit-per-cycle Q1/Q2 stream of an input DDR flop into WIDTH-bit
//   words, one word every WIDTH/2 cycles, with bit-granular word-boundary
//   adjustment. One instance per serial lane.
//
//   Ports:
//     C    rising-edge clock
//     R    asynchronous reset, active low
//     bus  iddr_gearbox_if.slave (Q1, Q2, BITSLIP in; DOUT, DVALID, SLIP_CNT,
//          ALIGNED out)
//
//   Optional feature: define IDDR_GEARBOX_AUTOALIGN_EN to build the
//   SEARCH/WAIT/LOCKED training-pattern aligner. In that build the aligner is
//   the only slip source and BITSLIP only drops an established lock. Without
//   it, BITSLIP is the slip source and ALIGNED is constant 0.
module iddr_gearbox #(
    parameter int unsigned      WIDTH         = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'h5C,
    parameter int unsigned      LOCK_COUNT    = 4,
    parameter int unsigned      SLIP_WAIT     = 2
) (
    input  logic          C,
    input  logic          R,
    iddr_gearbox_if.slave bus
);

    localparam int unsigned    HALF     = WIDTH / 2;
    localparam int unsigned    PHW      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [PHW-1:0] PH_LAST  = PHW'(HALF - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    // Only the low WIDTH-1 history bits ever reach a later word; the top two
    // bits of the WIDTH+1-bit window exist only in h_next.
    logic [WIDTH-2:0] hist;
    logic [WIDTH:0]   h_next;
    logic [PHW-1:0]   ph;
    logic             off;
    logic             stretch;
    logic             busy;
    logic [WIDTH-1:0] dout_q;
    logic             dvalid_q;
    logic [CW-1:0]    slip_cnt_q;
    logic             aligned_q;
    logic             slip_req;
    logic             slip_acc;
    logic             emit;

    always_comb begin
        h_next   = {hist, bus.Q1, bus.Q2};
        // A pending stretch holds ph at its last value for one extra cycle;
        // the word goes out on that extension cycle instead.
        emit     = (ph == PH_LAST) && !stretch;
        slip_acc = slip_req && !busy;
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            hist       <= '0;
            ph         <= '0;
            off        <= 1'b0;
            stretch    <= 1'b0;
            busy       <= 1'b0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            slip_cnt_q <= '0;
        end else begin
            hist     <= h_next[WIDTH-2:0];
            dvalid_q <= emit;

            // off is sampled before this cycle's slip, so a slip that lands on
            // an emission cycle only affects the following word.
            if (emit) begin
                dout_q <= off ? h_next[WIDTH:1] : h_next[WIDTH-1:0];
                ph     <= '0;
            end else if (ph != PH_LAST) begin
                ph <= ph + 1'b1;
            end

            if ((ph == PH_LAST) && stretch) begin
                stretch <= 1'b0;
            end

            if (slip_acc) begin
                // off 1->0 takes the newer window; off 0->1 takes the older
                // window and pays for it with one extra cycle in the period.
                off <= ~off;
                if (!off) begin
                    stretch <= 1'b1;
                end
                slip_cnt_q <= (slip_cnt_q == CNT_LAST) ? '0 : slip_cnt_q + 1'b1;
                busy       <= 1'b1;
            end else if (emit) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef IDDR_GEARBOX_AUTOALIGN_EN
    typedef enum logic [1:0] {
        S_SEARCH,
        S_WAIT,
        S_LOCKED
    } state_t;

    localparam int unsigned MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int unsigned WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    state_t        state;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] wait_cnt;
    logic          auto_slip;

    // The slip request is registered, so it reaches the datapath in the second
    // cycle of the next word period and shifts that word.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state     <= S_SEARCH;
            match_cnt <= '0;
            wait_cnt  <= '0;
            auto_slip <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            auto_slip <= 1'b0;
            case (state)
                S_SEARCH: begin
                    if (dvalid_q) begin
                        if (dout_q == TRAIN_PATTERN) begin
                            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                                state     <= S_LOCKED;
                                aligned_q <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            wait_cnt  <= '0;
                            auto_slip <= 1'b1;
                            state     <= (SLIP_WAIT == 0) ? S_SEARCH : S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dvalid_q) begin
                        if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
                            state <= S_SEARCH;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (bus.BITSLIP) begin
                        state     <= S_SEARCH;
                        aligned_q <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                default: begin
                    state <= S_SEARCH;
                end
            endcase
        end
    end

    assign slip_req = auto_slip;
`else
    assign slip_req  = bus.BITSLIP;
    assign aligned_q = 1'b0;
`endif

    assign bus.DOUT     = dout_q;
    assign bus.DVALID   = dvalid_q;
    assign bus.SLIP_CNT = slip_cnt_q;
    assign bus.ALIGNED  = aligned_q;

endmodule
